// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity encodings, FSM state types,
// and helpers that derive the per-bit clock count and its counter width.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_CLEANUP
    } rx_state_t;

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned calc_cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampler and frame FSM.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting over mid-1/mid/mid+1 samples.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = PARITY_EVEN,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 rx_error
);

    localparam int unsigned     CW        = calc_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int unsigned     WIN       = 3;
`else
    localparam int unsigned     WIN       = 2;
`endif

    rx_state_t              state;
    logic                   sync_meta;
    logic [WIN-1:0]         win;
    logic                   line_now;
    logic                   sample_bit;
    logic                   par_ok;
    logic [CW-1:0]          cnt;
    logic [3:0]             idx;
    logic                   stop_idx;
    logic                   par_acc;
    logic                   stop_ok;
    logic [DATA_BITS-1:0]   shift;

    // win[1] is the synchronised "now"; win[0] is one clock ahead, win[2] one behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            win       <= '1;
        end else begin
            sync_meta <= rx_serial;
            win       <= {win[WIN-2:0], sync_meta};
        end
    end

    assign line_now = win[1];
`ifdef UART_RX_MAJORITY_VOTE_EN
    assign sample_bit = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
`else
    assign sample_bit = win[1];
`endif

    assign par_ok = (PARITY == PARITY_NONE) ? 1'b1 :
                    (PARITY == PARITY_ODD)  ? par_acc : ~par_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            par_acc  <= 1'b0;
            stop_ok  <= 1'b1;
            shift    <= '0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            rx_error <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!line_now) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (sample_bit) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            idx     <= '0;
                            par_acc <= 1'b0;
                            stop_ok <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {sample_bit, shift[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ sample_bit;
                        if (idx == DATA_LAST) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_acc <= par_acc ^ sample_bit;
                        state   <= RX_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            if (par_ok && stop_ok && sample_bit) begin
                                rx_data  <= shift;
                                rx_ready <= 1'b1;
                            end else begin
                                rx_error <= 1'b1;
                            end
                            state <= RX_CLEANUP;
                        end else begin
                            stop_ok  <= stop_ok & sample_bit;
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_CLEANUP: begin
                    // a frame with a low stop bit must not re-trigger as a start
                    if (line_now) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_rx_module.sv
// Full-duplex UART: inline transmitter FSM plus a uart_rx instance, shared baud setting.
// Optional macro UART_RX_MAJORITY_VOTE_EN selects majority-vote sampling in the receiver.
module uart_tx_rx_module
    import uart_pkg::*;
#(
    parameter int unsigned UART_BAUD_RATE           = 9600,
    parameter int unsigned CLOCK_FREQUENCY          = 50000000,
    parameter int unsigned PARITY                   = 2,
    parameter int unsigned NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int unsigned NUMBER_STOP_BITS         = 1
) (
    input  logic                                IN_CLOCK,
    input  logic                                IN_RESET_N,
    input  logic                                IN_TX_LAUNCH,
    input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0] IN_TX_DATA,
    input  logic                                IN_RX_SERIAL,
    output logic                                OUT_TX_SERIAL,
    output logic                                OUT_TX_ACTIVE,
    output logic                                OUT_TX_DONE,
    output logic                                OUT_TX_START_BIT_ACTIVE,
    output logic                                OUT_TX_STOP_BIT_ACTIVE,
    output logic                                OUT_RX_DATA_READY,
    output logic [NUM_OF_DATA_BITS_IN_PACK-1:0] OUT_RX_DATA,
    output logic                                OUT_RX_ERROR
);

    localparam int unsigned   N         = NUM_OF_DATA_BITS_IN_PACK;
    localparam int unsigned   CLKS      = calc_clks_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
    localparam int unsigned   CW        = calc_cnt_width(CLKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS - 1);
    localparam logic [3:0]    DATA_LAST = 4'(N - 1);
    localparam logic          STOP_LAST = 1'(NUMBER_STOP_BITS - 1);

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_idx;
    logic            tx_stop_idx;
    logic [N-1:0]    tx_shift;
    logic            tx_par;
    logic            launch_prev;
    logic            bit_end;

    assign bit_end = (tx_cnt == BIT_LAST);

    // Transmit FSM; data shifts out LSB first, parity captured at launch
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            tx_state                <= TX_IDLE;
            tx_cnt                  <= '0;
            tx_idx                  <= '0;
            tx_stop_idx             <= 1'b0;
            tx_shift                <= '0;
            tx_par                  <= 1'b0;
            launch_prev             <= 1'b0;
            OUT_TX_SERIAL           <= 1'b1;
            OUT_TX_ACTIVE           <= 1'b0;
            OUT_TX_DONE             <= 1'b0;
            OUT_TX_START_BIT_ACTIVE <= 1'b0;
            OUT_TX_STOP_BIT_ACTIVE  <= 1'b0;
        end else begin
            launch_prev <= IN_TX_LAUNCH;
            OUT_TX_DONE <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (IN_TX_LAUNCH && !launch_prev) begin
                        tx_shift                <= IN_TX_DATA;
                        tx_par                  <= (PARITY == PARITY_ODD) ? ~(^IN_TX_DATA) : ^IN_TX_DATA;
                        tx_cnt                  <= '0;
                        tx_state                <= TX_START;
                        OUT_TX_SERIAL           <= 1'b0;
                        OUT_TX_ACTIVE           <= 1'b1;
                        OUT_TX_START_BIT_ACTIVE <= 1'b1;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx_cnt                  <= '0;
                        tx_idx                  <= '0;
                        OUT_TX_SERIAL           <= tx_shift[0];
                        tx_shift                <= tx_shift >> 1;
                        OUT_TX_START_BIT_ACTIVE <= 1'b0;
                        tx_state                <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        tx_cnt <= '0;
                        if (tx_idx == DATA_LAST) begin
                            if (PARITY != PARITY_NONE) begin
                                OUT_TX_SERIAL <= tx_par;
                                tx_state      <= TX_PARITY;
                            end else begin
                                OUT_TX_SERIAL          <= 1'b1;
                                OUT_TX_STOP_BIT_ACTIVE <= 1'b1;
                                tx_stop_idx            <= 1'b0;
                                tx_state               <= TX_STOP;
                            end
                        end else begin
                            tx_idx        <= tx_idx + 4'd1;
                            OUT_TX_SERIAL <= tx_shift[0];
                            tx_shift      <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_PARITY: begin
                    if (bit_end) begin
                        tx_cnt                 <= '0;
                        OUT_TX_SERIAL          <= 1'b1;
                        OUT_TX_STOP_BIT_ACTIVE <= 1'b1;
                        tx_stop_idx            <= 1'b0;
                        tx_state               <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        tx_cnt <= '0;
                        if (tx_stop_idx == STOP_LAST) begin
                            OUT_TX_DONE            <= 1'b1;
                            OUT_TX_ACTIVE          <= 1'b0;
                            OUT_TX_STOP_BIT_ACTIVE <= 1'b0;
                            tx_state               <= TX_DONE;
                        end else begin
                            tx_stop_idx <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DONE:  tx_state <= TX_IDLE;
                default:  tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_rx #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (N),
        .PARITY       (PARITY),
        .STOP_BITS    (NUMBER_STOP_BITS)
    ) u_rx (
        .clk       (IN_CLOCK),
        .rst_n     (IN_RESET_N),
        .rx_serial (IN_RX_SERIAL),
        .rx_data   (OUT_RX_DATA),
        .rx_ready  (OUT_RX_DATA_READY),
        .rx_error  (OUT_RX_ERROR)
    );

endmodule

// File: tb/tb_uart_tx_rx_module.sv
// Directed self-checking bench: 4 clk/bit, 8 data bits, even parity, 1 stop bit.
// Instance dut drives peer's RX; in ping-pong mode peer's TX also drives dut's RX.
module tb_uart_tx_rx_module;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dut_launch, peer_launch;
    logic [7:0] dut_tx_data, peer_tx_data;
    logic       bench_rx;
    logic       pp_mode;
    logic       dut_rx_in;

    logic       dut_tx, dut_act, dut_done, dut_start, dut_stop, dut_rdy, dut_err;
    logic [7:0] dut_rx_data;
    logic       peer_tx, peer_act, peer_done, peer_start, peer_stop, peer_rdy, peer_err;
    logic [7:0] peer_rx_data;

    int checks = 0;
    int passes = 0;
    int dut_done_n = 0, dut_act_n = 0, dut_start_n = 0, dut_stop_n = 0;
    int dut_rdy_n = 0, dut_err_n = 0, peer_rdy_n = 0, peer_err_n = 0, peer_act_n = 0;

    always #5 clk = ~clk;

    assign dut_rx_in = pp_mode ? peer_tx : bench_rx;

    uart_tx_rx_module #(
        .UART_BAUD_RATE(9600), .CLOCK_FREQUENCY(38400), .PARITY(2),
        .NUM_OF_DATA_BITS_IN_PACK(8), .NUMBER_STOP_BITS(1)
    ) dut (
        .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_TX_LAUNCH(dut_launch), .IN_TX_DATA(dut_tx_data),
        .IN_RX_SERIAL(dut_rx_in), .OUT_TX_SERIAL(dut_tx), .OUT_TX_ACTIVE(dut_act),
        .OUT_TX_DONE(dut_done), .OUT_TX_START_BIT_ACTIVE(dut_start), .OUT_TX_STOP_BIT_ACTIVE(dut_stop),
        .OUT_RX_DATA_READY(dut_rdy), .OUT_RX_DATA(dut_rx_data), .OUT_RX_ERROR(dut_err)
    );

    uart_tx_rx_module #(
        .UART_BAUD_RATE(9600), .CLOCK_FREQUENCY(38400), .PARITY(2),
        .NUM_OF_DATA_BITS_IN_PACK(8), .NUMBER_STOP_BITS(1)
    ) peer (
        .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_TX_LAUNCH(peer_launch), .IN_TX_DATA(peer_tx_data),
        .IN_RX_SERIAL(dut_tx), .OUT_TX_SERIAL(peer_tx), .OUT_TX_ACTIVE(peer_act),
        .OUT_TX_DONE(peer_done), .OUT_TX_START_BIT_ACTIVE(peer_start), .OUT_TX_STOP_BIT_ACTIVE(peer_stop),
        .OUT_RX_DATA_READY(peer_rdy), .OUT_RX_DATA(peer_rx_data), .OUT_RX_ERROR(peer_err)
    );

    // event counters sampled away from the active edge
    always @(negedge clk) begin
        if (dut_done)  dut_done_n++;
        if (dut_act)   dut_act_n++;
        if (dut_start) dut_start_n++;
        if (dut_stop)  dut_stop_n++;
        if (dut_rdy)   dut_rdy_n++;
        if (dut_err)   dut_err_n++;
        if (peer_rdy)  peer_rdy_n++;
        if (peer_err)  peer_err_n++;
        if (peer_act)  peer_act_n++;
    end

    task automatic pulse_dut_launch(input logic [7:0] d);
        dut_tx_data = d;
        dut_launch  = 1'b1;
        repeat (2) @(negedge clk);
        dut_launch  = 1'b0;
    endtask

    task automatic pulse_peer_launch(input logic [7:0] d);
        peer_tx_data = d;
        peer_launch  = 1'b1;
        repeat (2) @(negedge clk);
        peer_launch  = 1'b0;
    endtask

    task automatic wait_ready(input bit on_peer, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (on_peer ? peer_rdy : dut_rdy) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // drives start, 8 data bits LSB first, parity (optionally corrupted), stop
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            bench_rx = bits[b];
            repeat (4) @(negedge clk);
        end
        bench_rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dut_tx, dut_act, dut_done, dut_start, dut_stop} !== 5'b10000)
            $display("FAIL reset_tx_flags got=%b want=10000", {dut_tx, dut_act, dut_done, dut_start, dut_stop});
        else passes++;
        checks++;
        if ({dut_rdy, dut_err, dut_rx_data} !== 10'h000)
            $display("FAIL reset_rx got rdy=%b err=%b data=%h want 0/0/00", dut_rdy, dut_err, dut_rx_data);
        else passes++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tx_frame;
        logic [10:0] exp_bits;
        int a0, s0, p0, d0;
        exp_bits = 11'b100_1010_1010;   // stop, parity 0, 0x55 reversed, start
        a0 = dut_act_n; s0 = dut_start_n; p0 = dut_stop_n; d0 = dut_done_n;
        dut_tx_data = 8'h55;
        dut_launch  = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 12) dut_launch = 1'b0;
            checks++;
            if (n <= 44 && dut_tx !== exp_bits[(n - 1) / 4])
                $display("FAIL tx_bit sample=%0d got=%b want=%b", n, dut_tx, exp_bits[(n - 1) / 4]);
            else if (n > 44 && dut_tx !== 1'b1)
                $display("FAIL tx_idle sample=%0d got=%b want=1", n, dut_tx);
            else passes++;
            if (n == 45) begin
                checks++;
                if (dut_done !== 1'b1 || dut_act !== 1'b0)
                    $display("FAIL tx_done_timing got done=%b act=%b want 1/0", dut_done, dut_act);
                else passes++;
            end
        end
        checks++;
        if (dut_start_n - s0 !== 4) $display("FAIL start_len got=%0d want=4", dut_start_n - s0);
        else passes++;
        checks++;
        if (dut_stop_n - p0 !== 4) $display("FAIL stop_len got=%0d want=4", dut_stop_n - p0);
        else passes++;
        checks++;
        if (dut_done_n - d0 !== 1) $display("FAIL done_count got=%0d want=1", dut_done_n - d0);
        else passes++;
        checks++;
        if (dut_act_n - a0 !== 44) $display("FAIL active_len got=%0d want=44", dut_act_n - a0);
        else passes++;
    endtask

    task automatic test_ping_pong;
        bit seen;
        int e1, e2, pa;
        int unsigned sum;
        pp_mode = 1'b1;
        e1 = dut_err_n; e2 = peer_err_n;
        pulse_dut_launch(8'h55);
        wait_ready(1'b1, seen);
        checks++;
        if (!seen || peer_rx_data !== 8'h55) $display("FAIL pp_hop1 seen=%b got=%h want=55", seen, peer_rx_data);
        else passes++;
        sum = 32'(peer_rx_data) + 32'd64;
        if (sum < 255) pulse_peer_launch(8'(sum));
        wait_ready(1'b0, seen);
        checks++;
        if (!seen || dut_rx_data !== 8'h95) $display("FAIL pp_hop2 seen=%b got=%h want=95", seen, dut_rx_data);
        else passes++;
        sum = 32'(dut_rx_data) + 32'd64;
        if (sum < 255) pulse_dut_launch(8'(sum));
        wait_ready(1'b1, seen);
        checks++;
        if (!seen || peer_rx_data !== 8'hD5) $display("FAIL pp_hop3 seen=%b got=%h want=D5", seen, peer_rx_data);
        else passes++;
        sum = 32'(peer_rx_data) + 32'd64;
        pa = peer_act_n;
        if (sum < 255) pulse_peer_launch(8'(sum));
        repeat (100) @(negedge clk);
        checks++;
        if (peer_act_n !== pa) $display("FAIL pp_stop peer active cycles=%0d want=0", peer_act_n - pa);
        else passes++;
        checks++;
        if (dut_err_n !== e1 || peer_err_n !== e2)
            $display("FAIL pp_errors got=%0d/%0d want=0/0", dut_err_n - e1, peer_err_n - e2);
        else passes++;
        pp_mode = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_error_frames;
        int r0, e0;
        r0 = dut_rdy_n; e0 = dut_err_n;
        send_frame(8'h5A, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        checks++;
        if (dut_rdy_n - r0 !== 1 || dut_err_n !== e0 || dut_rx_data !== 8'h5A)
            $display("FAIL good_frame rdy=%0d err=%0d data=%h want 1/0/5A", dut_rdy_n - r0, dut_err_n - e0, dut_rx_data);
        else passes++;
        r0 = dut_rdy_n; e0 = dut_err_n;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        checks++;
        if (dut_rdy_n !== r0 || dut_err_n - e0 !== 1 || dut_rx_data !== 8'h5A)
            $display("FAIL bad_parity rdy=%0d err=%0d data=%h want 0/1/5A", dut_rdy_n - r0, dut_err_n - e0, dut_rx_data);
        else passes++;
        r0 = dut_rdy_n; e0 = dut_err_n;
        send_frame(8'h0F, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        checks++;
        if (dut_rdy_n !== r0 || dut_err_n - e0 !== 1 || dut_rx_data !== 8'h5A)
            $display("FAIL bad_stop rdy=%0d err=%0d data=%h want 0/1/5A", dut_rdy_n - r0, dut_err_n - e0, dut_rx_data);
        else passes++;
    endtask

    task automatic test_false_start;
        int r0, e0;
        r0 = dut_rdy_n; e0 = dut_err_n;
        bench_rx = 1'b0;
        @(negedge clk);
        bench_rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (dut_rdy_n !== r0 || dut_err_n !== e0)
            $display("FAIL false_start rdy=%0d err=%0d want 0/0", dut_rdy_n - r0, dut_err_n - e0);
        else passes++;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        checks++;
        if (dut_rdy_n - r0 !== 1 || dut_err_n !== e0 || dut_rx_data !== 8'h3C)
            $display("FAIL after_glitch rdy=%0d err=%0d data=%h want 1/0/3C", dut_rdy_n - r0, dut_err_n - e0, dut_rx_data);
        else passes++;
    endtask

    task automatic test_busy_and_reset;
        int d0, a0, r0;
        d0 = dut_done_n; a0 = dut_act_n; r0 = peer_rdy_n;
        pulse_dut_launch(8'h3C);
        repeat (20) @(negedge clk);
        pulse_dut_launch(8'hFF);
        repeat (120) @(negedge clk);
        checks++;
        if (dut_done_n - d0 !== 1 || dut_act_n - a0 !== 44)
            $display("FAIL busy_ignore done=%0d act=%0d want 1/44", dut_done_n - d0, dut_act_n - a0);
        else passes++;
        checks++;
        if (peer_rdy_n - r0 !== 1 || peer_rx_data !== 8'h3C)
            $display("FAIL busy_data rdy=%0d data=%h want 1/3C", peer_rdy_n - r0, peer_rx_data);
        else passes++;
        d0 = dut_done_n;
        pulse_dut_launch(8'hA5);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_tx, dut_act, dut_start, dut_stop} !== 4'b1000)
            $display("FAIL midframe_reset got=%b want=1000", {dut_tx, dut_act, dut_start, dut_stop});
        else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (dut_done_n !== d0) $display("FAIL abort_done got=%0d want=0", dut_done_n - d0);
        else passes++;
        d0 = dut_done_n; r0 = peer_rdy_n;
        pulse_dut_launch(8'hC3);
        repeat (70) @(negedge clk);
        checks++;
        if (dut_done_n - d0 !== 1 || peer_rdy_n - r0 !== 1 || peer_rx_data !== 8'hC3)
            $display("FAIL post_reset done=%0d rdy=%0d data=%h want 1/1/C3", dut_done_n - d0, peer_rdy_n - r0, peer_rx_data);
        else passes++;
    endtask

    initial begin
        rst_n        = 1'b0;
        dut_launch   = 1'b0;
        peer_launch  = 1'b0;
        dut_tx_data  = 8'h00;
        peer_tx_data = 8'h00;
        bench_rx     = 1'b1;
        pp_mode      = 1'b0;
        test_reset();
        test_tx_frame();
        test_ping_pong();
        test_error_frames();
        test_false_start();
        test_busy_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
